frame_bank_ctrl: RTL
====================

# frame_bank_ctrl

Double-buffer scheduler for the frame memory between the SPI data path and the VGA scan-out. It requests one frame from the data FSM and steers incoming pixel bits into the write bank. At each VGA frame boundary it swaps banks if the write bank is full; otherwise it repeats the displayed frame and flags an underrun. It sits between MODE_FSM/DATA_FSM and the two frame RAM banks, and replaces the direct start_req OR of switch_mode/start_data_FSM.

## Interface
Parameters:
- FRAME_PIXELS, 19200, pixel bits per frame (1 bit/pixel); must be ≥ 2
- ADDR_W, 15, frame RAM address width; 2^ADDR_W ≥ FRAME_PIXELS

Ports:
- CLK_40  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  playback active (from MODE_FSM); level
- frame_start  in  1  one-cycle pulse at VGA vertical blanking start
- wr_valid  in  1  pixel strobe (data_clk_rising_edge), one cycle per bit
- wr_bit  in  1  pixel value (received_bit), qualified by wr_valid
- start_req  out  1  one-cycle pulse: DATA_FSM fetches next frame
- wr_en  out  1  frame RAM write enable
- wr_bank  out  1  bank being written
- wr_addr  out  ADDR_W  write address
- wr_data  out  1  write data
- rd_bank  out  1  bank VGA reads
- display_valid  out  1  rd_bank holds a complete frame
- underrun  out  1  one-cycle pulse: frame_start with write bank incomplete

## Operation
- States: IDLE, REQ, FILL, FULL.
- IDLE: counter cleared. enable=1 → REQ.
- REQ: start_req=1 for exactly this one cycle → FILL.
- FILL: each wr_valid writes wr_bit at wr_addr, then increments wr_addr. The write at address FRAME_PIXELS-1 → FULL, and wr_addr returns to 0.
- FULL: wr_valid ignored. frame_start → swap (rd_bank←wr_bank, wr_bank←~wr_bank, display_valid←1) → REQ.
- frame_start in FILL without a final write: underrun pulse, no swap, rd_bank unchanged (frame repeats), fill continues.
- Final write and frame_start in the same cycle: the write completes and the swap happens that cycle → REQ. No underrun.
- frame_start in IDLE/REQ: ignored.
- wr_valid outside FILL: ignored; wr_en stays 0.
- enable=0 in any state → IDLE next cycle. wr_addr clears, display_valid clears, and any partial frame is discarded. Bank assignment is kept.
- wr_bank ≠ rd_bank at all times.

## Timing
- Reset values: state IDLE; start_req 0, wr_en 0, wr_addr 0, wr_data 0, wr_bank 0, rd_bank 1, display_valid 0, underrun 0.
- enable rise at cycle n → REQ at n+1 (start_req high during n+1) → FILL at n+2.
- wr_en, wr_addr, wr_data, wr_bank are registered: a wr_valid sampled at cycle n is presented at n+1.
- Swap is registered: frame_start at cycle n → new rd_bank and display_valid visible at n+1, start_req at n+1.
- underrun is high during the cycle after the offending frame_start.
- Reset assertion mid-fill: all outputs return to reset values immediately (asynchronously).

## Configuration
- FRAME_BANK_STATS_EN defined:
  - adds output drop_count (8 bits, reset 0), which increments on each underrun and saturates at 255;
  - adds input stats_clr (1 bit), which zeroes drop_count synchronously. If stats_clr and underrun coincide, the clear wins.
- Undefined: neither port exists, and there is no counter logic.

## Structure
- Shared package frame_bank_pkg holds:
  - the state enum (IDLE, REQ, FILL, FULL);
  - default FRAME_PIXELS and ADDR_W constants;
  - the drop counter width constant.
- No sub-module: the address counter and bank toggle stay inline with the FSM.

## Test plan
All scenarios use FRAME_PIXELS=8.
- Reset release, enable=1 → exactly one start_req pulse two cycles later; wr_bank=0, rd_bank=1, display_valid=0.
- 8 wr_valid strobes with bits 10110010 → wr_en 8 times at addr 0..7 with matching data, state FULL. A 9th strobe → no wr_en.
- FULL then frame_start → next cycle rd_bank=0, wr_bank=1, display_valid=1, start_req=1.
- 5 strobes then frame_start → underrun pulse, rd_bank unchanged. 3 more strobes then frame_start → swap, no underrun.
- 8th strobe and frame_start in the same cycle → swap, underrun stays 0.
- enable dropped after 3 strobes → IDLE, display_valid=0. Re-enable → fill restarts at wr_addr 0. With FRAME_BANK_STATS_EN, 300 underruns → drop_count=255.

Source files
------------

// File: rtl/frame_bank_pkg.sv
// frame_bank_pkg: shared state enum and default sizing for the frame bank scheduler
package frame_bank_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL, FULL} fb_state_t;
  localparam int FRAME_PIXELS_DEF = 19200;
  localparam int ADDR_W_DEF = 15;
  localparam int DROP_W = 8;
endpackage

// File: rtl/frame_bank_ctrl.sv
// frame_bank_ctrl: double-buffer scheduler steering SPI pixel bits into the write bank, swapping at VGA frame boundaries
// Optional FRAME_BANK_STATS_EN adds a saturating underrun counter (drop_count) with synchronous clear (stats_clr).
module frame_bank_ctrl
  import frame_bank_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              wr_valid,
  input  logic              wr_bit,
`ifdef FRAME_BANK_STATS_EN
  input  logic              stats_clr,
  output logic [DROP_W-1:0] drop_count,
`endif
  output logic              start_req,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              rd_bank,
  output logic              display_valid,
  output logic              underrun
);
  fb_state_t r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, r_wr_addr;
  logic r_wr_en, r_wr_data, r_wr_bank, r_disp, r_underrun;
  logic w_write, w_last, w_swap, w_under;
  always_comb begin
    w_write = enable && r_state == FILL && wr_valid;
    w_last  = w_write && r_cnt == ADDR_W'(FRAME_PIXELS - 1);
    w_swap  = enable && frame_start && (r_state == FULL || (r_state == FILL && w_last));
    w_under = enable && frame_start && r_state == FILL && !w_last;
    w_next  = r_state;
    if (!enable)
      w_next = IDLE;
    else
      case (r_state)
        IDLE: w_next = REQ;
        REQ:  w_next = FILL;
        FILL: w_next = w_swap ? REQ : (w_last ? FULL : FILL);
        FULL: w_next = frame_start ? REQ : FULL;
        default: w_next = IDLE;
      endcase
  end
  always_ff @(posedge CLK_40 or negedge reset)
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= 1'b0;
      r_wr_bank  <= 1'b0;
      r_disp     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wr_en    <= w_write;
      r_underrun <= w_under;
      if (!enable || r_state == IDLE)
        r_cnt <= '0;
      else if (w_write)
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (!enable)
        r_wr_addr <= '0;
      else if (w_write)
        r_wr_addr <= r_cnt;
      if (w_write)
        r_wr_data <= wr_bit;
      // read bank is always the complement of the write bank, so a swap is a single toggle
      if (w_swap)
        r_wr_bank <= ~r_wr_bank;
      if (!enable)
        r_disp <= 1'b0;
      else if (w_swap)
        r_disp <= 1'b1;
    end
`ifdef FRAME_BANK_STATS_EN
  logic [DROP_W-1:0] r_drop;
  always_ff @(posedge CLK_40 or negedge reset)
    if (!reset)
      r_drop <= '0;
    else if (stats_clr)
      r_drop <= '0;
    else if (w_under && r_drop != '1)
      r_drop <= r_drop + 1'b1;
  assign drop_count = r_drop;
`endif
  assign start_req     = r_state == REQ;
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign wr_bank       = r_wr_bank;
  assign rd_bank       = ~r_wr_bank;
  assign display_valid = r_disp;
  assign underrun      = r_underrun;
endmodule
